// File: rtl/regfile_mp_pkg.sv
// Shared constants and elaboration helpers for the t16q multi-port register file.
package regfile_pkg;

    // Write port 0 carries memory-load returns and is the only port that retires loads.
    localparam int WR_PORT_MEM = 0;

    // Index width for a register count.
    function automatic int calc_iw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // True when n is a power of two and at least 2.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, write ports, load-issue and status.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int NREGS = 16,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int IW = calc_iw(NREGS);

    logic [XLEN-1:0]          ir;
    logic [NRD-1:0][IW-1:0]   rd_idx;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][IW-1:0]   wr_idx;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     ld_issue_en;
    logic [IW-1:0]            ld_issue_idx;
    logic                     any_busy;

    modport master (
        input  ir, rd_data, rd_busy, any_busy,
        output rd_idx, wr_en, wr_idx, wr_data, ld_issue_en, ld_issue_idx
    );

    modport slave (
        output ir, rd_data, rd_busy, any_busy,
        input  rd_idx, wr_en, wr_idx, wr_data, ld_issue_en, ld_issue_idx
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by load issue,
// cleared by a memory-port write; a same-edge set beats the clear.
module regfile_scoreboard #(
    parameter int NREGS = 16,
    parameter int IW    = 4,
    parameter int NRD   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_en,
    input  logic [IW-1:0]          issue_idx,
    input  logic                   clr_en,
    input  logic [IW-1:0]          clr_idx,
    input  logic [NRD-1:0][IW-1:0] rd_idx,
    output logic [NRD-1:0]         rd_busy,
    output logic                   any_busy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;

    // Next busy vector: issue sets, memory write clears, set wins on collision.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            if (issue_en && (issue_idx == IW'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (clr_en && (clr_idx == IW'(r))) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
    end

    // Busy state, updated on the falling clock edge like the register array.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Per-port lookup and summary, from registered state only.
    always_comb begin
        for (int q = 0; q < NRD; q++) begin
            rd_busy[q] = busy_r[rd_idx[q]];
        end
        any_busy = |busy_r;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the t16q core. Register 0 is
// the IR; state changes on the falling edge of clk (the ph0 phase).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = 16,
    parameter int NREGS     = 16,
    parameter int NRD       = 2,
    parameter int NWR       = 2,
    parameter int ZERO_READ = 1,
    parameter int BYPASS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);

    localparam int IW = calc_iw(NREGS);

    typedef logic [IW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] reg_word_t;

    if (!is_pow2(NREGS)) begin : g_nregs_chk
        $error("regfile_mp: NREGS must be a power of two and at least 2");
    end

    reg_word_t                regs_r    [NREGS];
    reg_word_t                next_s    [NREGS];
    logic [NRD-1:0][XLEN-1:0] rd_data_s;
    logic [NRD-1:0]           rd_busy_s;
    logic [NRD-1:0]           sb_busy_s;
    logic                     any_busy_s;

    // Priority write mux: later (higher-numbered) ports override earlier ones.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            next_s[r] = regs_r[r];
            for (int p = 0; p < NWR; p++) begin
                next_s[r] = (bus.wr_en[p] && (bus.wr_idx[p] == reg_idx_t'(r)))
                          ? bus.wr_data[p] : next_s[r];
            end
        end
    end

    // Register array, including the IR at index 0.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r <= '{default: '0};
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= next_s[r];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .IW    (IW),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_en  (bus.ld_issue_en),
        .issue_idx (bus.ld_issue_idx),
        .clr_en    (bus.wr_en[WR_PORT_MEM]),
        .clr_idx   (bus.wr_idx[WR_PORT_MEM]),
        .rd_idx    (bus.rd_idx),
        .rd_busy   (sb_busy_s),
        .any_busy  (any_busy_s)
    );

    // Read ports: zero rule first, then same-edge bypass, then stored value.
    always_comb begin
        logic      hit;
        reg_word_t byp;
        for (int q = 0; q < NRD; q++) begin
            hit = 1'b0;
            byp = '0;
            for (int p = 0; p < NWR; p++) begin
                hit = (bus.wr_en[p] && (bus.wr_idx[p] == bus.rd_idx[q])) ? 1'b1 : hit;
                byp = (bus.wr_en[p] && (bus.wr_idx[p] == bus.rd_idx[q])) ? bus.wr_data[p] : byp;
            end
            if ((ZERO_READ != 0) && (bus.rd_idx[q] == '0)) begin
                rd_data_s[q] = '0;
                rd_busy_s[q] = 1'b0;
            end else begin
                rd_busy_s[q] = sb_busy_s[q];
                // Writes are dropped during reset, so they must not bypass either.
                if ((BYPASS != 0) && rst_n && hit) begin
                    rd_data_s[q] = byp;
                end else begin
                    rd_data_s[q] = regs_r[bus.rd_idx[q]];
                end
            end
        end
    end

    assign bus.ir       = regs_r[0];
    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.any_busy = any_busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default build, ZERO_READ=0 build and a wide
// 3-read/3-write no-bypass build, checked through an expectation queue.
module tb_regfile_mp;

    logic clk = 1'b1;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(16), .NREGS(16), .NRD(2), .NWR(2)) a_if ();
    regfile_mp_if #(.XLEN(16), .NREGS(16), .NRD(2), .NWR(2)) b_if ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(3), .NWR(3)) c_if ();

    regfile_mp #(.XLEN(16), .NREGS(16), .NRD(2), .NWR(2), .ZERO_READ(1), .BYPASS(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    regfile_mp #(.XLEN(16), .NREGS(16), .NRD(2), .NWR(2), .ZERO_READ(0), .BYPASS(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3), .NWR(3), .ZERO_READ(1), .BYPASS(0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Single comparison point: counts and reports.
    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_value("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_value(e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        a_if.wr_en = '0; a_if.ld_issue_en = 1'b0;
        b_if.wr_en = '0; b_if.ld_issue_en = 1'b0;
        c_if.wr_en = '0; c_if.ld_issue_en = 1'b0;
    endtask

    // Start of a drive cycle: just after the rising edge, all strobes low.
    task automatic drive_start();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Let the falling (update) edge pass, drop strobes, then settle.
    task automatic edge_idle();
        @(negedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.rd_idx = '0; a_if.wr_idx = '0; a_if.wr_data = '0; a_if.ld_issue_idx = '0;
        b_if.rd_idx = '0; b_if.wr_idx = '0; b_if.wr_data = '0; b_if.ld_issue_idx = '0;
        c_if.rd_idx = '0; c_if.wr_idx = '0; c_if.wr_data = '0; c_if.ld_issue_idx = '0;
        idle();
        #1;
        push_exp("rst0_ir", 32'h0);
        push_exp("rst0_rd", 32'h0);
        push_exp("rst0_any", 32'h0);
        pop_check(32'(a_if.ir));
        pop_check(32'(a_if.rd_data[0]));
        pop_check(32'(a_if.any_busy));
        #1 rst_n = 1'b1;

        // Load IR and r3, issue a load to r9, then reset asynchronously mid-cycle.
        drive_start();
        a_if.wr_en = 2'b11;
        a_if.wr_idx[0] = 4'd0;  a_if.wr_data[0] = 16'h1234;
        a_if.wr_idx[1] = 4'd3;  a_if.wr_data[1] = 16'hBEEF;
        a_if.ld_issue_en = 1'b1; a_if.ld_issue_idx = 4'd9;
        a_if.rd_idx[0] = 4'd3;  a_if.rd_idx[1] = 4'd9;
        push_exp("pre_rst_r3", 32'hBEEF);
        push_exp("pre_rst_ir", 32'h1234);
        push_exp("pre_rst_busy", 32'h1);
        edge_idle();
        pop_check(32'(a_if.rd_data[0]));
        pop_check(32'(a_if.ir));
        pop_check(32'(a_if.rd_busy[1]));
        @(posedge clk);
        #2 rst_n = 1'b0;
        push_exp("rst_r3", 32'h0);
        push_exp("rst_ir", 32'h0);
        push_exp("rst_any", 32'h0);
        push_exp("rst_rdbusy", 32'h0);
        #1;
        pop_check(32'(a_if.rd_data[0]));
        pop_check(32'(a_if.ir));
        pop_check(32'(a_if.any_busy));
        pop_check(32'(a_if.rd_busy[1]));
        #1 rst_n = 1'b1;

        // Write conflict on r5: port 1 must win, also through the bypass.
        drive_start();
        a_if.wr_en = 2'b11;
        a_if.wr_idx[0] = 4'd5; a_if.wr_data[0] = 16'h1111;
        a_if.wr_idx[1] = 4'd5; a_if.wr_data[1] = 16'h2222;
        a_if.rd_idx[0] = 4'd5; a_if.rd_idx[1] = 4'd5;
        push_exp("cfl_byp0", 32'h2222);
        push_exp("cfl_byp1", 32'h2222);
        push_exp("cfl_stored", 32'h2222);
        #3;
        pop_check(32'(a_if.rd_data[0]));
        pop_check(32'(a_if.rd_data[1]));
        edge_idle();
        pop_check(32'(a_if.rd_data[0]));

        // IR load through index 0 on both 16-bit builds.
        drive_start();
        a_if.wr_en = 2'b01; a_if.wr_idx[0] = 4'd0; a_if.wr_data[0] = 16'h8001; a_if.rd_idx[0] = 4'd0;
        b_if.wr_en = 2'b01; b_if.wr_idx[0] = 4'd0; b_if.wr_data[0] = 16'h8001; b_if.rd_idx[0] = 4'd0;
        push_exp("a_zero_byp", 32'h0);
        push_exp("b_zero_byp", 32'h8001);
        push_exp("a_ir", 32'h8001);
        push_exp("a_zero_rd", 32'h0);
        push_exp("b_ir", 32'h8001);
        push_exp("b_zero_rd", 32'h8001);
        #3;
        pop_check(32'(a_if.rd_data[0]));
        pop_check(32'(b_if.rd_data[0]));
        edge_idle();
        pop_check(32'(a_if.ir));
        pop_check(32'(a_if.rd_data[0]));
        pop_check(32'(b_if.ir));
        pop_check(32'(b_if.rd_data[0]));

        // Single load on r7: ALU write keeps it busy, memory write retires it.
        a_if.rd_idx[1] = 4'd7;
        drive_start();
        a_if.ld_issue_en = 1'b1; a_if.ld_issue_idx = 4'd7;
        push_exp("ld_busy", 32'h1);
        push_exp("ld_any", 32'h1);
        edge_idle();
        pop_check(32'(a_if.rd_busy[1]));
        pop_check(32'(a_if.any_busy));

        drive_start();
        a_if.wr_en = 2'b10; a_if.wr_idx[1] = 4'd7; a_if.wr_data[1] = 16'h0055;
        push_exp("alu_wr_busy", 32'h1);
        push_exp("alu_wr_data", 32'h0055);
        edge_idle();
        pop_check(32'(a_if.rd_busy[1]));
        pop_check(32'(a_if.rd_data[1]));

        drive_start();
        a_if.wr_en = 2'b01; a_if.wr_idx[0] = 4'd7; a_if.wr_data[0] = 16'h00AA;
        push_exp("mem_pre_any", 32'h1);
        push_exp("mem_pre_busy", 32'h1);
        push_exp("mem_busy", 32'h0);
        push_exp("mem_any", 32'h0);
        push_exp("mem_data", 32'h00AA);
        #3;
        pop_check(32'(a_if.any_busy));
        pop_check(32'(a_if.rd_busy[1]));
        edge_idle();
        pop_check(32'(a_if.rd_busy[1]));
        pop_check(32'(a_if.any_busy));
        pop_check(32'(a_if.rd_data[1]));

        // Back-to-back load: new issue and retiring write on the same edge.
        drive_start();
        a_if.ld_issue_en = 1'b1; a_if.ld_issue_idx = 4'd7;
        edge_idle();
        drive_start();
        a_if.ld_issue_en = 1'b1; a_if.ld_issue_idx = 4'd7;
        a_if.wr_en = 2'b01; a_if.wr_idx[0] = 4'd7; a_if.wr_data[0] = 16'h0BB0;
        push_exp("b2b_data", 32'h0BB0);
        push_exp("b2b_busy", 32'h1);
        edge_idle();
        pop_check(32'(a_if.rd_data[1]));
        pop_check(32'(a_if.rd_busy[1]));
        drive_start();
        a_if.wr_en = 2'b01; a_if.wr_idx[0] = 4'd7; a_if.wr_data[0] = 16'h0CC0;
        push_exp("b2b_retire", 32'h0);
        edge_idle();
        pop_check(32'(a_if.rd_busy[1]));

        // Load pending on r0: hidden on the operand port only under the zero rule.
        drive_start();
        a_if.ld_issue_en = 1'b1; a_if.ld_issue_idx = 4'd0; a_if.rd_idx[0] = 4'd0;
        b_if.ld_issue_en = 1'b1; b_if.ld_issue_idx = 4'd0; b_if.rd_idx[0] = 4'd0;
        push_exp("a_r0_rdbusy", 32'h0);
        push_exp("a_r0_any", 32'h1);
        push_exp("b_r0_rdbusy", 32'h1);
        edge_idle();
        pop_check(32'(a_if.rd_busy[0]));
        pop_check(32'(a_if.any_busy));
        pop_check(32'(b_if.rd_busy[0]));
        drive_start();
        a_if.wr_en = 2'b01; a_if.wr_idx[0] = 4'd0; a_if.wr_data[0] = 16'h4321;
        b_if.wr_en = 2'b01; b_if.wr_idx[0] = 4'd0; b_if.wr_data[0] = 16'h4321;
        push_exp("a_r0_clr_any", 32'h0);
        push_exp("b_r0_clr_any", 32'h0);
        edge_idle();
        pop_check(32'(a_if.any_busy));
        pop_check(32'(b_if.any_busy));

        // Wide build without bypass: old value during the write cycle, new after.
        for (int q = 0; q < 3; q++) c_if.rd_idx[q] = 5'd31;
        drive_start();
        c_if.wr_en = 3'b100; c_if.wr_idx[2] = 5'd31; c_if.wr_data[2] = 32'h12345678;
        edge_idle();
        drive_start();
        c_if.wr_en = 3'b111;
        c_if.wr_idx[0] = 5'd31; c_if.wr_data[0] = 32'hAAAAAAAA;
        c_if.wr_idx[1] = 5'd30; c_if.wr_data[1] = 32'h30303030;
        c_if.wr_idx[2] = 5'd31; c_if.wr_data[2] = 32'hDEADBEEF;
        for (int q = 0; q < 3; q++) push_exp($sformatf("c_old_p%0d", q), 32'h12345678);
        for (int q = 0; q < 3; q++) push_exp($sformatf("c_new_p%0d", q), 32'hDEADBEEF);
        push_exp("c_r30", 32'h30303030);
        #3;
        for (int q = 0; q < 3; q++) pop_check(c_if.rd_data[q]);
        edge_idle();
        for (int q = 0; q < 3; q++) pop_check(c_if.rd_data[q]);
        c_if.rd_idx[1] = 5'd30;
        #1;
        pop_check(c_if.rd_data[1]);

        check_value("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general register file for the t16q core. Successor to the fixed 16x16, 2-read/2-write core register file.
- Keeps the core conventions:
  - register 0 holds the IR;
  - index 0 reads as zero on operand ports;
  - state updates on the falling edge of clk.ph0.
- Adds the following, beyond that block:
  - configurable width, depth and port counts;
  - asynchronous reset;
  - defined write-conflict priority;
  - optional write-through bypass;
  - a pending-load scoreboard so the sequencer can stall on registers awaiting memory.

Parameters:
- XLEN, 16, data width in bits.
- NREGS, 16, number of registers; power of two, >= 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports. Port 0 is the memory-load port.
- ZERO_READ, 1, when 1, index 0 reads as 0 on read ports (IR stays readable via ir).
- BYPASS, 1, when 1, read ports see same-edge write data combinationally.
- IW, $clog2(NREGS), index width (derived; not overridable).

Ports:
- clk  input  Clock interface  core clock; sampled edge is negedge clk.ph0.
- rst_n  input  1  asynchronous, active-low reset.
- ir  output  XLEN  contents of register 0, raw; never zeroed, never bypassed.
- rd_idx  input  NRD x IW  read port indices.
- rd_data  output  NRD x XLEN  read port data.
- rd_busy  output  NRD  1 = indexed register has a pending load.
- wr_en  input  NWR  write enables.
- wr_idx  input  NWR x IW  write indices.
- wr_data  input  NWR x XLEN  write data.
- ld_issue_en  input  1  marks ld_issue_idx pending.
- ld_issue_idx  input  IW  register targeted by an issued load.
- any_busy  output  1  OR of all scoreboard bits.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers (including IR) and all busy bits;
  - consequently ir=0, rd_data=0, rd_busy=0, any_busy=0;
  - writes and issues coincident with reset are dropped;
  - the first update is on the first negedge ph0 after rst_n rises.
- Writes:
  - on negedge ph0, each port with wr_en=1 writes wr_data to wr_idx;
  - all indices, including 0, are writable (0 = IR load path).
- Write conflict: when several enabled ports target the same index on one edge, the highest-numbered port wins (ALU beats memory load). Lower ports are discarded, with no error.
- Reads:
  - combinational;
  - rd_idx=0 with ZERO_READ=1 gives rd_data=0 and rd_busy=0;
  - otherwise rd_data = stored value.
- Bypass: with BYPASS=1, if an enabled write targets rd_idx in the current cycle, rd_data shows that wr_data, using the same priority as stored writes. The zero rule still overrides. With BYPASS=0 there is one-cycle read-after-write latency.
- Scoreboard:
  - one busy bit per register;
  - ld_issue_en sets busy[ld_issue_idx] on negedge ph0;
  - a port-0 write with wr_en[0]=1 clears busy[wr_idx[0]];
  - writes on ports >= 1 do not clear busy;
  - set and clear of the same index on the same edge: set wins (back-to-back loads);
  - issue to an already-busy register: remains busy, no counter;
  - rd_busy is registered-state only and is never bypassed.
- Width rules:
  - no arithmetic;
  - indices are exactly IW bits, so out-of-range is impossible;
  - NREGS must be a power of two, and this is checked by elaboration assertion.

Decomposition:
- Package regfile_pkg holds:
  - the function computing IW from NREGS;
  - the localparam WR_PORT_MEM = 0;
  - the typedefs reg_idx_t / reg_word_t, as parameterised packed types in the module.
- One natural sub-module, regfile_scoreboard (NREGS, IW). It covers:
  - the busy vector;
  - set/clear priority;
  - any_busy;
  - rd_busy lookup.
- The priority write mux is generated with a for-loop inside regfile_mp and is not a separate module.

Test Plan:
- Reset: write 0xBEEF to r3, then pulse rst_n low mid-cycle. Required: rd_data(r3)=0 and ir=0 immediately (asynchronous), with busy all 0.
- Conflict: same edge, port0 writes r5=0x1111 and port1 writes r5=0x2222. Required: r5=0x2222 afterwards. With BYPASS=1, rd_data shows 0x2222 in the write cycle.
- Zero/IR: write r0=0x8001. Required: ir=0x8001, rd_data(idx 0)=0 (ZERO_READ=1). With ZERO_READ=0, rd_data(idx 0)=0x8001.
- Scoreboard, single load: ld_issue r7, then port1 writes r7. Required: rd_busy stays 1. A subsequent port0 write of r7=0x00AA clears busy, and any_busy drops to 0 on the same edge.
- Scoreboard, back-to-back load: same edge, ld_issue r7 and port0 write r7. Required: r7 updated and busy remains 1.
- Configuration sweep:
  - XLEN=32, NREGS=32, NRD=3, NWR=3, BYPASS=0;
  - write r31=0xDEADBEEF;
  - required: old value read in the write cycle, new value the next cycle, on all three read ports.
